// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S master transmitter, divides the PLL clock into BCLK/FCLK and shifts out stereo frames
// Ports: pin_i2s_bclk_pll clock; pin_user_sw async active-low reset; en transmit enable (frame boundaries);
//   s_left/s_right/s_valid/s_ready sample-pair handshake into a one-pair shadow register;
//   i2s_bclk/i2s_fclk/i2s_data serial pins; frame_start/underrun one-clock pulses at frame load.
module i2s_master_tx #(
  parameter int BCLK_HALF = 1,
  parameter int DATA_W    = 32
) (
  input  logic              pin_i2s_bclk_pll,
  input  logic              pin_user_sw,
  input  logic              en,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              i2s_bclk,
  output logic              i2s_fclk,
  output logic              i2s_data,
  output logic              frame_start,
  output logic              underrun
);
  localparam int DW = BCLK_HALF > 1 ? $clog2(BCLK_HALF) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_HALF - 1);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0] k_q, k_d, k_nx, bit_idx;
  logic bclk_q, bclk_d, fclk_q, fclk_d, data_q, data_d, fs_q, fs_d, ur_q, ur_d;
  logic full_q, full_d, ld, wrap, fall;
  logic [63:0] frame_q, frame_d, shadow_q, shadow_d, s_pad;
  assign s_pad = {32'(s_left) << (32 - DATA_W), 32'(s_right) << (32 - DATA_W)};
  assign wrap = div_q == DIV_MAX;
  assign fall = state_q == RUN && wrap && bclk_q;
  assign k_nx = k_q + 6'd1;
  // slot k carries frame_q[64-k]; for k=0 this is frame_q[0], the previous frame's right LSB
  assign bit_idx = 6'd0 - k_nx;
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    k_d = k_q;
    bclk_d = bclk_q;
    fclk_d = fclk_q;
    data_d = data_q;
    frame_d = frame_q;
    shadow_d = shadow_q;
    full_d = full_q;
    fs_d = 1'b0;
    ur_d = 1'b0;
    ld = 1'b0;
    if (s_valid && !full_q) begin
      shadow_d = s_pad;
      full_d = 1'b1;
    end
    if (state_q == IDLE) begin
      if (en) begin
        state_d = RUN;
        ld = 1'b1;
      end
    end else begin
      div_d = wrap ? '0 : div_q + DW'(1);
      bclk_d = bclk_q ^ wrap;
      if (fall) begin
        if (k_q == 6'd63 && !en) begin
          state_d = IDLE;
          k_d = '0;
          fclk_d = 1'b0;
          data_d = 1'b0;
        end else begin
          k_d = k_nx;
          fclk_d = k_nx[5];
          data_d = frame_q[bit_idx];
          ld = k_nx == 6'd0;
        end
      end
    end
    // accept cannot coincide with a transfer: a transfer needs full_q, which holds s_ready low
    if (ld) begin
      frame_d = full_q ? shadow_q : '0;
      ur_d = !full_q;
      fs_d = 1'b1;
      if (full_q) full_d = 1'b0;
    end
  end
  always_ff @(posedge pin_i2s_bclk_pll or negedge pin_user_sw)
    if (!pin_user_sw) begin
      state_q <= IDLE;
      div_q <= '0;
      k_q <= '0;
      bclk_q <= 1'b0;
      fclk_q <= 1'b0;
      data_q <= 1'b0;
      fs_q <= 1'b0;
      ur_q <= 1'b0;
      full_q <= 1'b0;
      frame_q <= '0;
      shadow_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      k_q <= k_d;
      bclk_q <= bclk_d;
      fclk_q <= fclk_d;
      data_q <= data_d;
      fs_q <= fs_d;
      ur_q <= ur_d;
      full_q <= full_d;
      frame_q <= frame_d;
      shadow_q <= shadow_d;
    end
  assign s_ready = !full_q;
  assign i2s_bclk = bclk_q;
  assign i2s_fclk = fclk_q;
  assign i2s_data = data_q;
  assign frame_start = fs_q;
  assign underrun = ur_q;
endmodule

// File: tb/tb_i2s_master_tx.sv
// tb_i2s_master_tx: randomized bench checking i2s_master_tx against a slot-level model at two parameter points
module tb_i2s_master_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int H = g == 0 ? 1 : 3;
    localparam int W = g == 0 ? 32 : 24;
    localparam int P = 2 * H;
    localparam int FR = 64 * P;
    localparam logic [31:0] LIT_L = g == 0 ? 32'h80000001 : 32'h00ABCDEF;
    localparam logic [31:0] LIT_R = g == 0 ? 32'h7FFFFFFE : 32'h00123456;
    localparam logic [63:0] LIT_CAP = g == 0 ? 64'h80000001_7FFFFFFE : 64'hABCDEF00_12345600;
    logic rst_n = 1'b0, en = 1'b0, s_valid = 1'b0;
    logic [W-1:0] s_left = '0, s_right = '0;
    logic s_ready, bclk, fclk, data, fs, ur;
    i2s_master_tx #(.BCLK_HALF(H), .DATA_W(W)) dut (
      .pin_i2s_bclk_pll(clk), .pin_user_sw(rst_n), .en(en), .s_left(s_left), .s_right(s_right),
      .s_valid(s_valid), .s_ready(s_ready), .i2s_bclk(bclk), .i2s_fclk(fclk), .i2s_data(data),
      .frame_start(fs), .underrun(ur)
    );
    bit run = 0, first = 0, sh_full = 0, lsb = 0, e_fs = 0, e_ur = 0, acc, ld;
    int m = 0;
    logic [31:0] cur_l = '0, cur_r = '0, sh_l = '0, sh_r = '0;
    logic [63:0] frames[$];
    function automatic logic [31:0] pad(input logic [W-1:0] x);
      return 32'(x) << (32 - W);
    endfunction
    initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        run = 0;
        m = 0;
        sh_full = 0;
        e_fs = 0;
        e_ur = 0;
      end else begin
        acc = s_valid && !sh_full;
        ld = 0;
        e_fs = 0;
        e_ur = 0;
        if (!run) begin
          if (en) begin
            run = 1;
            m = 0;
            first = 1;
            ld = 1;
          end
        end else begin
          m = m + 1;
          if (m == FR) begin
            if (!en) run = 0;
            else begin
              m = 0;
              first = 0;
              lsb = cur_r[0];
              ld = 1;
            end
          end
        end
        if (ld) begin
          e_fs = 1;
          e_ur = !sh_full;
          cur_l = sh_full ? sh_l : '0;
          cur_r = sh_full ? sh_r : '0;
          sh_full = 0;
          frames.push_back({cur_l, cur_r});
        end
        if (acc) begin
          sh_l = pad(s_left);
          sh_r = pad(s_right);
          sh_full = 1;
        end
      end
    end
    int ur_cnt = 0, ncap = 0, rd = 0, slot;
    logic [31:0] sr = '0, cap_l = '0;
    logic last_f = 0, prev_b = 0, e_data;
    logic [63:0] last_cap = '0, exp_cap;
    logic [5:0] exp_v, act_v;
    initial forever begin
      @(negedge clk);
      slot = m / P;
      e_data = slot == 0 ? (!first && lsb) : slot <= 32 ? cur_l[32 - slot] : cur_r[64 - slot];
      exp_v = {!sh_full, run && ((m / H) % 2 == 1), run && slot >= 32, run && e_data, e_fs, e_ur};
      act_v = {s_ready, bclk, fclk, data, fs, ur};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL u%0d outputs t=%0t {ready,bclk,fclk,data,fs,ur} got %b expected %b", g, $time, act_v, exp_v);
      end
      if (ur === 1'b1) ur_cnt++;
      if (!run) begin
        sr = '0;
        last_f = 0;
        rd = frames.size();
      end else if (bclk && !prev_b) begin
        if (fclk != last_f) begin
          if (last_f) begin
            last_cap = {cap_l, sr[30:0], data};
            ncap++;
            exp_cap = rd < frames.size() ? frames[rd] : 'x;
            checks++;
            if (last_cap !== exp_cap) begin
              errors++;
              $display("FAIL u%0d capture t=%0t got %h expected %h", g, $time, last_cap, exp_cap);
            end
            rd++;
          end else cap_l = {sr[30:0], data};
          sr = '0;
        end else sr = {sr[30:0], data};
        last_f = fclk;
      end
      prev_b = bclk;
    end
    bit done = 0;
    task automatic step(input int n = 1);
      repeat (n) begin
        @(posedge clk);
        #2;
      end
    endtask
    task automatic lit(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL u%0d %s got %h expected %h", g, name, got, want);
      end
    endtask
    task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
      int t = 0;
      s_left = l;
      s_right = r;
      s_valid = 1'b1;
      while (s_ready !== 1'b1 && t < 3 * FR) begin
        step();
        t++;
      end
      lit("send_ready_within_bound", 64'(s_ready), 64'd1);
      step();
      s_valid = 1'b0;
    endtask
    task automatic wait_fs();
      int t = 0;
      while (fs !== 1'b1 && t < 2 * FR) begin
        step();
        t++;
      end
      lit("frame_start_within_bound", 64'(fs), 64'd1);
    endtask
    initial begin
      s_valid = 1'b1;
      s_left = W'(LIT_L);
      s_right = W'(LIT_R);
      step(10);
      lit("reset_ready", 64'(s_ready), 64'd1);
      lit("reset_pins", 64'({bclk, fclk, data, fs, ur}), 64'd0);
      rst_n = 1'b1;
      step();
      s_valid = 1'b0;
      lit("preload_ready_low", 64'(s_ready), 64'd0);
      step(2);
      en = 1'b1;
      wait_fs();
      lit("frame1_no_underrun", 64'(ur), 64'd0);
      lit("fclk_slot0", 64'(fclk), 64'd0);
      step(32 * P);
      lit("fclk_slot32", 64'(fclk), 64'd1);
      wait_fs();
      lit("underrun_pulse", 64'(ur), 64'd1);
      step(P);
      lit("capture_literal", last_cap, LIT_CAP);
      lit("capture_count", 64'(ncap), 64'd1);
      lit("underrun_count", 64'(ur_cnt), 64'd1);
      send(W'($urandom), W'($urandom));
      lit("held_ready_low", 64'(s_ready), 64'd0);
      send(W'($urandom), W'($urandom));
      send(W'($urandom), W'($urandom));
      repeat (6) begin
        step($urandom_range(0, FR));
        send(W'($urandom), W'($urandom));
      end
      wait_fs();
      step(10 * P);
      en = 1'b0;
      step(FR);
      lit("idle_after_stop", 64'({bclk, fclk, data}), 64'd0);
      step(FR);
      lit("still_idle", 64'({bclk, fclk, data, fs}), 64'd0);
      en = 1'b1;
      wait_fs();
      step(40 * P);
      #1 rst_n = 1'b0;
      #1;
      lit("midframe_reset_pins", 64'({bclk, fclk, data, fs, ur}), 64'd0);
      lit("midframe_reset_ready", 64'(s_ready), 64'd1);
      step(3);
      rst_n = 1'b1;
      step(5);
      done = 1;
    end
  end
  initial begin
    fork
      wait (u[0].done && u[1].done);
      begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
